// File: rtl/paddle_emu.sv
// paddle_emu: per-player paddle position latch and per-line countdown for the ay38500NTSC pot inputs.
// Build option: define PADDLE_ACCEL_EN for hold-to-accelerate in digital mode.
module paddle_emu #(
  parameter int unsigned STEP_SLOW    = 5,
  parameter int unsigned STEP_FAST    = 8,
  parameter int unsigned POS_INIT     = 128
`ifdef PADDLE_ACCEL_EN
  ,
  parameter int unsigned ACCEL_FRAMES = 16
`endif
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        speed,
  input  logic [1:0]  p1_mode,
  input  logic [1:0]  p2_mode,
  input  logic        p1_inv,
  input  logic        p2_inv,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [15:0] p1_analog,
  input  logic [15:0] p2_analog,
  input  logic [7:0]  p1_paddle,
  input  logic [7:0]  p2_paddle,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  p1_pos,
  output logic [7:0]  p2_pos
);

  typedef enum logic [1:0] {
    MODE_DIGITAL  = 2'd0,
    MODE_ANALOG_Y = 2'd1,
    MODE_ANALOG_X = 2'd2,
    MODE_PADDLE   = 2'd3
  } mode_e;

  localparam logic [7:0] POS_RST = 8'(POS_INIT);

  logic            hs_q, vs_q;
  logic            hs_rise, vs_rise;
  logic [1:0][7:0] pos_q, pos_d;
  logic [1:0][7:0] cap_q, cap_d;

  mode_e            mode [2];
  logic [1:0]       inv, up, dn;
  logic [1:0][15:0] analog;
  logic [1:0][7:0]  paddle;
  logic [7:0]       step_base, step_eff;
  logic [8:0]       sum9, diff9;

`ifdef PADDLE_ACCEL_EN
  localparam logic [4:0] ACC_MAX = 5'(ACCEL_FRAMES);
  logic [1:0][4:0] acc_q, acc_d;
`endif

  assign mode[0]   = mode_e'(p1_mode);
  assign mode[1]   = mode_e'(p2_mode);
  assign inv       = {p2_inv, p1_inv};
  assign up        = {p2_up, p1_up};
  assign dn        = {p2_down, p1_down};
  assign analog    = {p2_analog, p1_analog};
  assign paddle    = {p2_paddle, p1_paddle};
  assign step_base = speed ? 8'(STEP_FAST) : 8'(STEP_SLOW);

  assign hs_rise = hs & ~hs_q;
  assign vs_rise = vs & ~vs_q;

  // A vs rise wins over a coincident hs rise: reload only, no decrement.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    pos_d    = pos_q;
    cap_d    = cap_q;
    step_eff = step_base;
    sum9     = '0;
    diff9    = '0;
`ifdef PADDLE_ACCEL_EN
    acc_d    = acc_q;
`endif
    for (int p = 0; p < 2; p++) begin
      if (vs_rise) begin
        step_eff = step_base;
`ifdef PADDLE_ACCEL_EN
        if (acc_q[p] == ACC_MAX) step_eff = step_base << 1;
        if (mode[p] == MODE_DIGITAL && (up[p] ^ dn[p]))
          acc_d[p] = (acc_q[p] == ACC_MAX) ? acc_q[p] : acc_q[p] + 5'd1;
        else
          acc_d[p] = '0;
`endif
        sum9  = {1'b0, pos_q[p]} + {1'b0, step_eff};
        diff9 = {1'b0, pos_q[p]} - {1'b0, step_eff};
        case (mode[p])
          MODE_DIGITAL: begin
            cap_d[p] = pos_q[p] ^ {8{inv[p]}};
            if (dn[p])      pos_d[p] = sum9[8]  ? 8'hFF : sum9[7:0];
            else if (up[p]) pos_d[p] = diff9[8] ? 8'h00 : diff9[7:0];
          end
          MODE_ANALOG_Y: cap_d[p] = {~analog[p][15], analog[p][14:8]} ^ {8{inv[p]}};
          MODE_ANALOG_X: cap_d[p] = {~analog[p][7], analog[p][6:0]} ^ {8{inv[p]}};
          MODE_PADDLE:   cap_d[p] = paddle[p] ^ {8{inv[p]}};
          default:       cap_d[p] = cap_q[p];
        endcase
      end else if (hs_rise && cap_q[p] != 8'd0) begin
        cap_d[p] = cap_q[p] - 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      pos_q <= {POS_RST, POS_RST};
      cap_q <= '0;
`ifdef PADDLE_ACCEL_EN
      acc_q <= '0;
`endif
    end else begin
      hs_q  <= hs;
      vs_q  <= vs;
      pos_q <= pos_d;
      cap_q <= cap_d;
`ifdef PADDLE_ACCEL_EN
      acc_q <= acc_d;
`endif
    end
  end

  assign lp_in  = (cap_q[0] == 8'd0);
  assign rp_in  = (cap_q[1] == 8'd0);
  assign p1_pos = pos_q[0];
  assign p2_pos = pos_q[1];

endmodule
